// File: rtl/ps2_kbd_rx_pkg.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx_pkg
//   Shared definitions for the PS/2 keyboard receiver:
//     - Set-2 prefix byte constants (E0 extended, F0 break, E1 pause)
//     - device-reply codes that never form a key event
//     - frame FSM state encoding
//     - helper that classifies a byte as a device reply
//   No ports; imported by ps2_kbd_rx and ps2_line_filter.
// ---------------------------------------------------------------------------
package ps2_kbd_rx_pkg;

    // Set-2 prefix bytes
    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam logic [7:0] PS2_E1 = 8'hE1;

    // Replies sent by the keyboard itself rather than by a key
    localparam logic [7:0] PS2_BAT_OK  = 8'hAA;
    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_ECHO    = 8'hEE;
    localparam logic [7:0] PS2_RESEND  = 8'hFE;
    localparam logic [7:0] PS2_OVERRUN = 8'h00;
    localparam logic [7:0] PS2_ERROR   = 8'hFF;

    // Bytes following E1 in the Pause make sequence (14 77 E1 F0 14 F0 77)
    localparam int PAUSE_SKIP = 7;

    // Width of the inactivity counter
    localparam int TMO_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    function automatic logic is_device_reply(input logic [7:0] b);
        return (b == PS2_BAT_OK)  || (b == PS2_ACK)    ||
               (b == PS2_ECHO)    || (b == PS2_RESEND) ||
               (b == PS2_OVERRUN) || (b == PS2_ERROR);
    endfunction

endpackage

// File: rtl/ps2_kbd_rx_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter
//   Brings one raw, asynchronous PS/2 line into the clk domain and removes
//   glitches. A 2-FF synchronizer is followed by a stability filter: the
//   filtered level only follows the synchronized line after it has differed
//   from the current filtered level for FILTER_LEN consecutive cycles.
//
//   Ports:
//     clk      in   system clock
//     reset_n  in   asynchronous active-low reset (filtered level resets to 1)
//     line_i   in   raw line
//     line_o   out  synchronized, filtered level
// ---------------------------------------------------------------------------
module ps2_line_filter
    import ps2_kbd_rx_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_i,
    output logic line_o
);

    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // The counter tracks how long the synchronized line has disagreed with
    // the filtered level; any agreement restarts it, so short pulses never
    // reach the terminal count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign line_o = level_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
//   PS/2 keyboard receiver and Set-2 scan-code decoder. Deframes 11-bit
//   device-to-host frames (start, 8 data LSB first, odd parity, stop) and
//   folds E0/F0/E1 prefixes into single key events for the keyboard matrix.
//   Receive only: the PS/2 lines are never driven.
//
//   Ports:
//     clk           in   system clock
//     reset_n       in   asynchronous active-low reset
//     ps2_clk       in   raw PS/2 clock line
//     ps2_data      in   raw PS/2 data line
//     key_strobe    out  one-cycle pulse per key event
//     key_pressed   out  1 = make, 0 = break (held between events)
//     key_extended  out  event was E0-prefixed (held between events)
//     key_code      out  scan code without prefixes (held between events)
//     frame_err     out  one-cycle pulse on start/parity/stop error or timeout
// ---------------------------------------------------------------------------
module ps2_kbd_rx
    import ps2_kbd_rx_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 65536
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

    // ---------------- input conditioning ----------------
    logic clk_filt;
    logic data_filt;
    logic clk_prev_q;
    logic fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2_clk),
        .line_o  (clk_filt)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2_data),
        .line_o  (data_filt)
    );

    // Falling edge is decoded combinationally from the filtered level so the
    // FSM acts on it in the same cycle the filter switches.
    assign fall = clk_prev_q & ~clk_filt;

    // ---------------- state ----------------
    frame_state_e     state_q,    state_d;
    logic [2:0]       bit_cnt_q,  bit_cnt_d;
    logic [7:0]       shift_q,    shift_d;
    logic             par_q,      par_d;
    logic [TMO_W-1:0] tmo_q,      tmo_d;

    logic             ext_q,      ext_d;
    logic             brk_q,      brk_d;
    logic [2:0]       skip_q,     skip_d;

    logic             strobe_q,   strobe_d;
    logic             err_q,      err_d;
    logic             pressed_q,  pressed_d;
    logic             extended_q, extended_d;
    logic [7:0]       code_q,     code_d;

    logic             byte_ok;
    logic             byte_bad;

    // ---------------- frame FSM + decoder ----------------
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        ext_d      = ext_q;
        brk_d      = brk_q;
        skip_d     = skip_q;
        strobe_d   = 1'b0;
        err_d      = 1'b0;
        pressed_d  = pressed_q;
        extended_d = extended_q;
        code_d     = code_q;
        byte_ok    = 1'b0;
        byte_bad   = 1'b0;

        // Inactivity counter only runs inside a frame and saturates at the
        // limit so the comparison below stays true until the abort happens.
        if (fall || (state_q == ST_IDLE)) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_LIMIT) begin
            tmo_d = tmo_q + 1'b1;
        end

        if ((state_q != ST_IDLE) && (tmo_q == TMO_LIMIT)) begin
            // Abandoned frame: drop it and forget any pending prefix.
            state_d = ST_IDLE;
            err_d   = 1'b1;
            ext_d   = 1'b0;
            brk_d   = 1'b0;
            skip_d  = '0;
        end else if (fall) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!data_filt) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_filt, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = data_filt;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    // Odd parity: data plus parity bit must hold an odd
                    // number of ones.
                    if (data_filt && (^{shift_q, par_q})) begin
                        byte_ok = 1'b1;
                    end else begin
                        byte_bad = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (byte_bad) begin
            err_d  = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
            skip_d = '0;
        end else if (byte_ok) begin
            if (skip_q != 3'd0) begin
                // Inside the Pause sequence every byte is swallowed.
                skip_d = skip_q - 3'd1;
            end else if (shift_q == PS2_E0) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_F0) begin
                brk_d = 1'b1;
            end else if (shift_q == PS2_E1) begin
                skip_d = 3'(PAUSE_SKIP);
            end else if (!is_device_reply(shift_q)) begin
                strobe_d   = 1'b1;
                code_d     = shift_q;
                pressed_d  = ~brk_q;
                extended_d = ext_q;
                ext_d      = 1'b0;
                brk_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_prev_q <= 1'b1;
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            skip_q     <= '0;
            strobe_q   <= 1'b0;
            err_q      <= 1'b0;
            pressed_q  <= 1'b0;
            extended_q <= 1'b0;
            code_q     <= 8'h00;
        end else begin
            clk_prev_q <= clk_filt;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            skip_q     <= skip_d;
            strobe_q   <= strobe_d;
            err_q      <= err_d;
            pressed_q  <= pressed_d;
            extended_q <= extended_d;
            code_q     <= code_d;
        end
    end

    assign key_strobe   = strobe_q;
    assign frame_err    = err_q;
    assign key_pressed  = pressed_q;
    assign key_extended = extended_q;
    assign key_code     = code_q;

endmodule
